// File: rtl/cell_mem_access_ctrl.sv
// Single-owner access controller for one cell position memory.
// Round-robin arbitration between writeback (W), home-cell sweep (S) and
// random neighbour reads (R); one registered memory op per cycle, tagged
// read return after the memory read latency.
module cell_mem_access_ctrl #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220,
    parameter int RD_LATENCY   = 2
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  sweep_start,
    output logic                  sweep_busy,
    output logic                  sweep_done,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_gnt,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] rd_tag,
    output logic                  rd_src,
    output logic                  addr_err
);
    // stage 0 is the registered op; stage STAGES lines up with mem_q
    localparam int STAGES = RD_LATENCY;
    localparam int CW     = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;
    typedef enum logic [1:0] {SRC_W = 2'd0, SRC_S = 2'd1, SRC_R = 2'd2} src_t;

    typedef struct packed {
        logic                  vld;
        logic                  in_rng;
        logic                  src;
        logic [ADDR_WIDTH-1:0] tag;
    } rd_ent_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    src_t            prio;
    rd_ent_t         vld_pipe [STAGES:0];
    rd_ent_t         pipe_in;
    logic            gnt_w, gnt_s, gnt_r;
    logic            sw_req;
    logic            wr_in_rng, rd_in_rng;

    assign sw_req    = (state == SWEEP) && (cnt < CW'(PARTICLE_NUM));
    assign wr_in_rng = ({1'b0, wr_addr} < CW'(PARTICLE_NUM));
    assign rd_in_rng = ({1'b0, rd_addr} < CW'(PARTICLE_NUM));

    // Round-robin grant: prio holds the source that wins ties this cycle
    always_comb begin
        gnt_w = 1'b0;
        gnt_s = 1'b0;
        gnt_r = 1'b0;
        if (rst_n) begin
            case (prio)
                SRC_W: begin
                    if (wr_req)      gnt_w = 1'b1;
                    else if (sw_req) gnt_s = 1'b1;
                    else if (rd_req) gnt_r = 1'b1;
                end
                SRC_S: begin
                    if (sw_req)      gnt_s = 1'b1;
                    else if (rd_req) gnt_r = 1'b1;
                    else if (wr_req) gnt_w = 1'b1;
                end
                default: begin
                    if (rd_req)      gnt_r = 1'b1;
                    else if (wr_req) gnt_w = 1'b1;
                    else if (sw_req) gnt_s = 1'b1;
                end
            endcase
        end
    end

    assign wr_gnt = gnt_w;
    assign rd_gnt = gnt_r;

    // Register the granted op onto the memory port; out-of-range ops keep their slot but stay silent
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            mem_address <= '0;
            mem_data    <= '0;
            mem_rden    <= 1'b0;
            mem_wren    <= 1'b0;
            prio        <= SRC_W;
            addr_err    <= 1'b0;
        end else begin
            mem_rden <= 1'b0;
            mem_wren <= 1'b0;
            mem_data <= '0;
            if (gnt_w) begin
                mem_address <= wr_addr;
                mem_data    <= wr_data;
                mem_wren    <= wr_in_rng;
                prio        <= SRC_S;
            end else if (gnt_s) begin
                mem_address <= cnt[ADDR_WIDTH-1:0];
                mem_rden    <= 1'b1;
                prio        <= SRC_R;
            end else if (gnt_r) begin
                mem_address <= rd_addr;
                mem_rden    <= rd_in_rng;
                prio        <= SRC_W;
            end
            if ((gnt_w && !wr_in_rng) || (gnt_r && !rd_in_rng))
                addr_err <= 1'b1;
        end
    end

    // Descriptor of a granted read entering the return pipe
    always_comb begin
        pipe_in        = '0;
        pipe_in.vld    = gnt_s | gnt_r;
        pipe_in.in_rng = gnt_s | (gnt_r & rd_in_rng);
        pipe_in.src    = gnt_s;
        if (gnt_s)      pipe_in.tag = cnt[ADDR_WIDTH-1:0];
        else if (gnt_r) pipe_in.tag = rd_addr;
    end

    // Return pipe tracks valid/tag/source alongside the memory latency
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= STAGES; i++) vld_pipe[i] <= '0;
        end else begin
            vld_pipe[0] <= pipe_in;
            for (int i = 1; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign rd_valid   = vld_pipe[STAGES].vld;
    assign rd_tag     = vld_pipe[STAGES].tag;
    assign rd_src     = vld_pipe[STAGES].src;
    assign rd_data    = (vld_pipe[STAGES].vld && vld_pipe[STAGES].in_rng) ? mem_q : '0;
    assign sweep_done = (state == DRAIN) && rd_valid && rd_src
                        && (rd_tag == ADDR_WIDTH'(PARTICLE_NUM - 1));
    assign sweep_busy = (state != IDLE);

    // Sweep FSM: issue 0..PARTICLE_NUM-1, then wait for the last datum to return
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sweep_start) begin
                        state <= SWEEP;
                        cnt   <= '0;
                    end
                end
                SWEEP: begin
                    if (gnt_s) begin
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(PARTICLE_NUM - 1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (sweep_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cell_mem_access_ctrl.sv
// Randomized bench for cell_mem_access_ctrl: a behavioural model of the
// arbitration rules, sweep progress and memory contents predicts every
// grant, memory op and read return, cycle by cycle.
module tb_cell_mem_access_ctrl;
    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;
    localparam int RL = 2;

    logic          clock = 1'b0;
    logic          rst_n;
    logic          sweep_start, sweep_busy, sweep_done;
    logic          rd_req, rd_gnt, wr_req, wr_gnt;
    logic [AW-1:0] rd_addr, wr_addr, mem_address, rd_tag;
    logic [DW-1:0] wr_data, mem_data, mem_q, rd_data;
    logic          mem_rden, mem_wren, rd_valid, rd_src, addr_err;

    cell_mem_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN), .RD_LATENCY(RL)) dut (
        .clock(clock), .rst_n(rst_n),
        .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .mem_address(mem_address), .mem_data(mem_data), .mem_rden(mem_rden), .mem_wren(mem_wren),
        .mem_q(mem_q), .rd_valid(rd_valid), .rd_data(rd_data), .rd_tag(rd_tag), .rd_src(rd_src),
        .addr_err(addr_err)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] seed_word(input int i);
        return {32'(i) * 32'h9E3779B1, ~32'(i), 32'(i) ^ 32'h5A5A5A5A};
    endfunction

    // Memory: address register + output register; q is junk unless a read was issued
    logic [DW-1:0] ram [256];
    logic [AW-1:0] ram_a;
    logic          ram_rd;
    bit            ram_init;
    always @(posedge clock) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= seed_word(i);
            ram_init <= 1'b1;
        end else if (mem_wren) begin
            ram[mem_address] <= mem_data;
        end
        ram_a  <= mem_address;
        ram_rd <= mem_rden;
        mem_q  <= ram_rd ? ram[ram_a] : {$urandom, $urandom, $urandom};
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    typedef struct {
        int            due;
        logic [AW-1:0] tag;
        bit            src;
        logic [DW-1:0] data;
    } ret_t;

    // reference model state
    logic [DW-1:0] ref_mem [256];
    ret_t          retq [$];
    int            cyc, last_src, sw_next, last_sw_tag;
    bit            sw_on, err_m;
    bit            eo_rd, eo_wr;
    logic [AW-1:0] eo_a;
    logic [DW-1:0] eo_d;
    // observation counters
    int            dut_done_cnt, last_done_cyc, sw_ret_cnt;
    // generator knobs
    bit            gen_on;
    int            p_wr, p_rd, p_oor, p_start;

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(99) < p_oor) return AW'($urandom_range(PN, 255));
        return AW'($urandom_range(0, PN - 1));
    endfunction

    task automatic model_reset();
        retq.delete();
        sw_on = 0; sw_next = 0; err_m = 0; last_src = 2;
        eo_rd = 0; eo_wr = 0; eo_a = '0; eo_d = '0;
    endtask

    // One clock cycle: check the DUT against the model, advance the model, move the requesters
    task automatic step();
        bit pend [3];
        int g;
        bit busy_now, done_exp, n_rd, n_wr;
        logic [AW-1:0] n_a;
        logic [DW-1:0] n_d;
        ret_t r;
        #1;
        busy_now = sw_on;
        pend[0] = wr_req;
        pend[1] = sw_on && (sw_next < PN);
        pend[2] = rd_req;
        g = -1;
        for (int k = 1; k <= 3; k++)
            if (g < 0 && pend[(last_src + k) % 3]) g = (last_src + k) % 3;
        chk("wr_gnt", DW'(wr_gnt), DW'(g == 0));
        chk("rd_gnt", DW'(rd_gnt), DW'(g == 2));
        chk("sweep_busy", DW'(sweep_busy), DW'(busy_now));
        chk("mem_rden", DW'(mem_rden), DW'(eo_rd));
        chk("mem_wren", DW'(mem_wren), DW'(eo_wr));
        if (eo_rd || eo_wr) chk("mem_address", DW'(mem_address), DW'(eo_a));
        if (eo_wr) chk("mem_data", mem_data, eo_d);
        chk("addr_err", DW'(addr_err), DW'(err_m));
        done_exp = 0;
        if (retq.size() > 0 && retq[0].due == cyc) begin
            r = retq.pop_front();
            chk("rd_valid", DW'(rd_valid), DW'(1));
            chk("rd_tag", DW'(rd_tag), DW'(r.tag));
            chk("rd_src", DW'(rd_src), DW'(r.src));
            chk("rd_data", rd_data, r.data);
            if (r.src) last_sw_tag = int'(r.tag);
            done_exp = r.src && (r.tag == AW'(PN - 1));
        end else begin
            chk("rd_valid_idle", DW'(rd_valid), DW'(0));
        end
        chk("sweep_done", DW'(sweep_done), DW'(done_exp));
        if (sweep_done) begin dut_done_cnt++; last_done_cyc = cyc; end
        if (rd_valid && rd_src) sw_ret_cnt++;

        n_rd = 0; n_wr = 0; n_a = '0; n_d = '0;
        if (g == 0) begin
            n_a = wr_addr; n_d = wr_data;
            if (int'(wr_addr) < PN) begin ref_mem[wr_addr] = wr_data; n_wr = 1; end
            else err_m = 1;
        end else if (g == 1) begin
            r.due = cyc + 1 + RL; r.tag = AW'(sw_next); r.src = 1; r.data = ref_mem[sw_next];
            retq.push_back(r);
            n_rd = 1; n_a = AW'(sw_next); sw_next++;
        end else if (g == 2) begin
            r.due = cyc + 1 + RL; r.tag = rd_addr; r.src = 0; n_a = rd_addr;
            if (int'(rd_addr) < PN) begin r.data = ref_mem[rd_addr]; n_rd = 1; end
            else begin r.data = '0; err_m = 1; end
            retq.push_back(r);
        end
        if (g >= 0) last_src = g;
        if (!busy_now && sweep_start) begin sw_on = 1; sw_next = 0; last_sw_tag = -1; end
        if (done_exp) sw_on = 0;

        @(posedge clock);
        cyc++;
        eo_rd = n_rd; eo_wr = n_wr; eo_a = n_a; eo_d = n_d;
        @(negedge clock);
        if (g == 0) wr_req = 0;
        if (g == 2) rd_req = 0;
        sweep_start = 0;
        if (gen_on) begin
            if (!wr_req && $urandom_range(99) < p_wr) begin
                wr_req = 1; wr_addr = rnd_addr(); wr_data = {$urandom, $urandom, $urandom};
            end
            if (!rd_req && $urandom_range(99) < p_rd) begin
                rd_req = 1; rd_addr = rnd_addr();
            end
            if ($urandom_range(99) < p_start) sweep_start = 1;
        end
    endtask

    // Asynchronous reset mid-cycle: outputs must clear without waiting for a clock edge
    task automatic do_reset();
        rst_n = 0; wr_req = 0; rd_req = 0; sweep_start = 0;
        #1;
        chk("rst_ctrl", DW'({rd_valid, sweep_busy, sweep_done, mem_rden, mem_wren, rd_src,
                             addr_err, rd_gnt, wr_gnt}), DW'(0));
        chk("rst_addr", DW'({mem_address, rd_tag}), DW'(0));
        chk("rst_data", mem_data | rd_data, DW'(0));
        model_reset();
        @(posedge clock);
        @(negedge clock);
        rst_n = 1;
    endtask

    task automatic run_until_done(input int budget, input string tag);
        int d0;
        d0 = dut_done_cnt;
        for (int i = 0; i < budget && dut_done_cnt == d0; i++) step();
        chk(tag, DW'(dut_done_cnt - d0), DW'(1));
    endtask

    task automatic run_until_tag(input int t, input int budget, input string tag);
        int i;
        for (i = 0; i < budget && last_sw_tag != t; i++) step();
        chk(tag, DW'(last_sw_tag), DW'(t));
    endtask

    initial begin
        int t0, d0;
        for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
        rst_n = 1; wr_req = 0; rd_req = 0; sweep_start = 0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        gen_on = 0; p_wr = 0; p_rd = 0; p_oor = 0; p_start = 0;
        cyc = 0; dut_done_cnt = 0; last_done_cyc = 0; sw_ret_cnt = 0; last_sw_tag = -1;
        model_reset();
        @(negedge clock);
        do_reset();

        // write 5 then read it back
        wr_req = 1; wr_addr = 8'd5; wr_data = 96'h1;
        step(); step();
        rd_req = 1; rd_addr = 8'd5;
        repeat (6) step();

        // lone sweep: latency, count and order
        sw_ret_cnt = 0; t0 = cyc; sweep_start = 1;
        run_until_done(400, "sweep_alone_done");
        chk("sweep_alone_latency", DW'(last_done_cyc - t0), DW'(223));
        repeat (3) step();
        chk("sweep_alone_count", DW'(sw_ret_cnt), DW'(PN));

        // all three sources saturated
        gen_on = 1; p_wr = 100; p_rd = 100; p_oor = 0; p_start = 0;
        wr_req = 1; wr_addr = rnd_addr(); wr_data = {$urandom, $urandom, $urandom};
        rd_req = 1; rd_addr = rnd_addr();
        t0 = cyc; sweep_start = 1;
        run_until_done(900, "sweep_loaded_done");
        chk("sweep_loaded_share", DW'((last_done_cyc - t0) >= 650 && (last_done_cyc - t0) <= 680), DW'(1));
        gen_on = 0; wr_req = 0; rd_req = 0;
        repeat (6) step();

        // out-of-range read and write
        rd_req = 1; rd_addr = 8'd220; wr_req = 1; wr_addr = 8'd255; wr_data = '1;
        repeat (10) step();
        chk("addr_err_sticky", DW'(addr_err), DW'(1));

        // reset in the middle of a sweep
        sweep_start = 1;
        run_until_tag(100, 400, "sweep_reach_100");
        do_reset();
        d0 = dut_done_cnt;
        repeat (300) step();
        chk("no_done_after_reset", DW'(dut_done_cnt - d0), DW'(0));
        sweep_start = 1;
        run_until_done(400, "sweep_after_reset");

        // sweep_start while busy is ignored
        d0 = dut_done_cnt;
        sweep_start = 1;
        run_until_tag(50, 400, "sweep_reach_50");
        sweep_start = 1;
        step();
        run_until_done(400, "sweep_restart_ignored");
        repeat (300) step();
        chk("single_done", DW'(dut_done_cnt - d0), DW'(1));

        // random mix
        gen_on = 1; p_wr = 35; p_rd = 35; p_oor = 10; p_start = 3;
        repeat (4000) step();
        gen_on = 0; wr_req = 0; rd_req = 0; sweep_start = 0;
        repeat (700) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cell_mem_access_ctrl.md
Name: cell_mem_access_ctrl

Overview:
- Single-owner access controller for one cell position memory (single-port, DATA_WIDTH word = {posz, posy, posx}).
- Arbitrates one memory operation per cycle between three requesters:
  - the motion-update writeback;
  - an internal full-cell sweep (home-cell streaming to the force pipeline);
  - random neighbour-fetch reads.
- Returns tagged read data with a valid strobe. One instance sits beside each cell memory in RL_LJ_Top.

Parameters:
- DATA_WIDTH, 96: memory word width (3 x fp32).
- ADDR_WIDTH, 8: memory address width.
- PARTICLE_NUM, 220: valid words in the cell; addresses >= PARTICLE_NUM are out of range.
- RD_LATENCY, 2: cycles from mem_address/mem_rden valid to mem_q valid (address register + output register).

Ports:
- clock  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- sweep_start  in  1  pulse; start a sweep of addresses 0..PARTICLE_NUM-1.
- sweep_busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse with the last sweep read datum.
- rd_req  in  1  random read request; held until granted.
- rd_addr  in  ADDR_WIDTH  random read address.
- rd_gnt  out  1  combinational grant for rd_req.
- wr_req  in  1  write request; held until granted.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_gnt  out  1  combinational grant for wr_req.
- mem_address  out  ADDR_WIDTH  to memory address.
- mem_data  out  DATA_WIDTH  to memory data.
- mem_rden  out  1  to memory rden.
- mem_wren  out  1  to memory wren.
- mem_q  in  DATA_WIDTH  from memory q.
- rd_valid  out  1  read data valid.
- rd_data  out  DATA_WIDTH  read data (mem_q, or zero for an out-of-range read).
- rd_tag  out  ADDR_WIDTH  address of the returned datum.
- rd_src  out  1  0 = random read, 1 = sweep.
- addr_err  out  1  sticky; set on any out-of-range grant, cleared only by reset.

Behaviour:
- Reset (rst_n low, async):
  - all outputs 0; FSM = IDLE; sweep counter 0; round-robin pointer = WRITE; read valid pipeline flushed.
  - Reset mid-sweep abandons the sweep; no sweep_done is produced.
- Sources: W (wr_req), S (sweep pending: FSM in SWEEP and counter < PARTICLE_NUM), R (rd_req).
- Arbitration:
  - round-robin over W, S, R; the last-granted source has lowest priority next cycle;
  - exactly one grant per cycle; no grant when nothing is pending;
  - gnt is combinational in cycle t; the requester drops or changes req after seeing gnt at the clock edge.
- Memory drive:
  - granted op is registered, so mem_address/mem_data/mem_rden/mem_wren are valid in cycle t+1;
  - idle cycle gives mem_rden = mem_wren = 0;
  - never both rden and wren in the same cycle.
- Read return:
  - a read granted in cycle t gives rd_valid in cycle t+1+RD_LATENCY (t+3 at default);
  - rd_tag and rd_src travel through a RD_LATENCY+1 deep shift register with the valid bit;
  - rd_data = mem_q when valid and in range, otherwise 0.
- Write followed by read of the same address in a later grant cycle returns the new data.
- Out-of-range address (>= PARTICLE_NUM):
  - the op is still granted and addr_err is set;
  - a write issues no mem_wren;
  - a read issues no mem_rden but still produces rd_valid with rd_data = 0.
- Sweep FSM: IDLE -> SWEEP -> DRAIN -> IDLE.
  - IDLE: sweep_start goes to SWEEP, counter = 0, sweep_busy = 1.
  - SWEEP: each S grant issues a read of the counter value and increments the counter. When the grant of address PARTICLE_NUM-1 occurs, go to DRAIN.
  - DRAIN: no S requests. sweep_done pulses in the cycle the rd_valid for address PARTICLE_NUM-1 (rd_src = 1) is asserted. Go to IDLE; sweep_busy falls the next cycle.
  - sweep_start while sweep_busy is ignored.
- Sweep data is returned in strictly ascending address order. Random reads may interleave and are distinguished by rd_src.
- Worst-case share: each source gets at least 1 of every 3 cycles while pending.

Test Plan:
1. Reset, then a single write of addr 5 = 96'h1 -> mem_wren=1, mem_address=5 in cycle t+1; then a read of addr 5 -> rd_valid at grant+3 with rd_data=96'h1, rd_tag=5, rd_src=0.
2. sweep_start with no other traffic -> 220 consecutive rd_valid, tags 0..219, rd_src=1; sweep_done coincident with tag 219; sweep_busy low one cycle later; 223 cycles from start grant to done.
3. W, R and the sweep all pending continuously -> grant order cycles W, S, R, W, ...; each stream completes in order; the sweep takes about 660 cycles; no cycle has both mem_rden and mem_wren.
4. Read of addr 220 and write of addr 255 -> addr_err=1 and stays set; no mem_rden/mem_wren for either; rd_valid with rd_data=0, rd_tag=220.
5. rst_n low at sweep tag 100 -> all outputs 0 immediately; no sweep_done ever; a new sweep_start restarts from tag 0.
6. sweep_start pulsed at tag 50 during a sweep -> ignored; exactly one sweep_done, after tag 219.
